dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port word data memory between the core load/store path (port 0) and a debug/loader port (port 1).
//  Implements RV32I byte/half/word access over 32-bit word storage, sign/zero-extends load data and flags misaligned accesses.
//  Sits between the core/debug requesters and the memory's a/wd/we/rd pins. Memory read is combinational; memory write is on the clk edge.
// PARAMETERS
//  AW      32  byte-address width of requests and of mem_a
//  STARVE  4   consecutive port-0 grants while port 1 waits before port 1 is forced
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  req[1:0]   in   2   per-port request, held until ack
//  we[1:0]    in   2   per-port write enable (1=store)
//  addr0/1    in   AW  per-port byte address
//  wdata0/1   in   32  per-port store data, right-aligned
//  funct3_0/1 in   3   RV32I size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ack[1:0]   out  2   one-cycle completion pulse to the granted port
//  rdata      out  32  extended load data, valid with ack
//  err        out  1   misaligned/illegal funct3, valid with ack
//  mem_a      out  AW  memory word address = {addr[AW-1:2],2'b00}
//  mem_wd     out  32  merged write word
//  mem_we     out  1   memory write strobe
//  mem_rd     in   32  memory read word, combinational from mem_a
// BEHAVIOUR
//  Reset: state IDLE, ack=0, err=0, rdata=0, mem_we=0, mem_a=0, mem_wd=0, starve count=0, grant pointer=port 0.
//  FSM: IDLE -> ACCESS -> (MERGE for B/H store) -> DONE -> IDLE.
//   IDLE: when any req is high, latch the winner's addr/wdata/we/funct3 and go to ACCESS. No req: stay IDLE.
//   Arbitration: port 0 wins, unless port 1 has waited STARVE grants, then port 1 wins and the count clears.
//   The count increments only when port 0 is granted while req[1]=1. A port-1 grant also clears it.
//   ACCESS: drive mem_a. Run the alignment check: H needs addr[0]=0, W needs addr[1:0]=0.
//    Funct3 011, 110 and 111 are illegal. A misaligned or illegal access goes to DONE with err=1; no memory write.
//    Load: capture mem_rd, select the byte or half via addr[1:0], extend it (B/H sign, BU/HU zero), go to DONE.
//    Word store: mem_we=1 for exactly this cycle, mem_wd=wdata, go to DONE.
//    B/H store: capture mem_rd into the merge register, go to MERGE.
//   MERGE: replace byte lane addr[1:0] (or half lane addr[1]) with the low bits of wdata.
//    mem_we=1 for exactly this cycle with the merged word; go to DONE.
//   DONE: ack[winner]=1 for one cycle, rdata/err valid the same cycle, go to IDLE.
//    rdata=0 for stores and errors.
//  Latency, req to ack: load or word store 3 cycles; B/H store 4 cycles; error 3 cycles.
//  Back-to-back: a req still high in IDLE after DONE is re-arbitrated. A requester drops req in the cycle after ack.
//  Request changes after grant are ignored because fields are latched. Dropping req mid-transaction does not abort it.
//  mem_we is never high outside ACCESS/MERGE and never high with err.
//  rst mid-transaction returns to IDLE next edge with no further mem_we and no ack. A pending RMW write is discarded.
//  Simultaneous req with port-1 starvation pending: port 1 wins.
// STRUCTURE
//  Shared package: funct3 size encodings (F3_B/H/W/BU/HU) and FSM state encodings.
//  One sub-module: lsu_align. It is combinational and does the lane select + extension for loads, the lane merge for stores, and the misalign/illegal decode.
//  The arbiter FSM and starve counter stay in this module.
// TESTING
//  LW at 0x10 after SW 0xDEADBEEF at 0x10 (port 0) -> ack0 at cycle 3, rdata=0xDEADBEEF, err=0.
//  Word 0x11223344 at 0x20; SB 0xAA to 0x21 -> mem_we once in MERGE; LW 0x20 reads 0x1122AA44; LB 0x21=0xFFFFFFAA; LBU=0x000000AA.
//  SH 0x8001 to 0x22 over 0x11223344 -> word 0x80013344. LH 0x22=0xFFFF8001; LHU=0x00008001.
//  LW at 0x13 and SH at 0x21 -> err=1, rdata=0, mem_we never asserted, memory word unchanged.
//  req0 held continuously with req1=1 -> port 1 acked after exactly 4 port-0 acks; then the count restarts.
//  rst asserted during MERGE of SB 0x55 to 0x30 -> no write; word at 0x30 keeps its old value; no ack; FSM in IDLE.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: RV32I load/store size codes and FSM states.
// Combinational-only declarations, no latency or backpressure.
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Byte and half stores need a read-modify-write pass through MERGE.
    function automatic logic is_subword_store(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/dmem_arbiter_lsu_align.sv
// Lane select/extend for loads, lane merge for stores, misalign/illegal decode; purely combinational.
// Zero latency; no backpressure, results follow inputs in the same cycle.
module lsu_align
    import dmem_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rd_word[8*addr_lo +: 8];
        half_sel  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        merged    = rd_word;
        err       = 1'b0;
        case (funct3)
            F3_B: begin
                load_data = {{24{byte_sel[7]}}, byte_sel};
                merged[8*addr_lo +: 8] = wdata[7:0];
            end
            F3_BU: load_data = {24'h0, byte_sel};
            F3_H: begin
                err       = addr_lo[0];
                load_data = {{16{half_sel[15]}}, half_sel};
                merged[16*addr_lo[1] +: 16] = wdata[15:0];
            end
            F3_HU: begin
                err       = addr_lo[0];
                load_data = {16'h0, half_sel};
            end
            F3_W: begin
                err       = |addr_lo;
                load_data = rd_word;
                merged    = wdata;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto a single-port word memory; req->ack 3 cycles (load, word store, error), 4 for B/H store.
// Backpressure: req is held until the one-cycle ack; a losing port just waits, port 1 is forced after STARVE port-0 grants.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW     = 32,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [2:0]    funct3_0,
    input  logic [2:0]    funct3_1,
    output logic [1:0]    ack,
    output logic [31:0]   rdata,
    output logic          err,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd
);

    localparam int CW = $clog2(STARVE + 1);

    state_t        state, state_nxt;
    logic          win_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   merge_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] starve_cnt;

    logic          grant1;
    logic [31:0]   align_rd;
    logic [31:0]   load_data;
    logic [31:0]   merged;
    logic          align_err;

    assign grant1 = req[1] && (!req[0] || (starve_cnt >= CW'(STARVE)));

    // In MERGE the memory word comes from the captured copy, not the live read port.
    assign align_rd = (state == ST_MERGE) ? merge_q : mem_rd;

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .rd_word   (align_rd),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged),
        .err       (align_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        ack       = 2'b00;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (align_err) begin
                    state_nxt = ST_DONE;
                end else if (we_q && is_subword_store(f3_q)) begin
                    state_nxt = ST_MERGE;
                end else begin
                    state_nxt = ST_DONE;
                    mem_we    = we_q;
                end
            end
            ST_MERGE: begin
                state_nxt = ST_DONE;
                mem_we    = 1'b1;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                ack       = win_q ? 2'b10 : 2'b01;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A reset landing on a write cycle must not reach the memory.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    assign mem_a  = {addr_q[AW-1:2], 2'b00};
    assign mem_wd = mem_we ? merged : 32'h0;
    assign rdata  = rdata_q;
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    if (|req) begin
                        win_q   <= grant1;
                        addr_q  <= grant1 ? addr1    : addr0;
                        wdata_q <= grant1 ? wdata1   : wdata0;
                        we_q    <= grant1 ? we[1]    : we[0];
                        f3_q    <= grant1 ? funct3_1 : funct3_0;
                        if (grant1) begin
                            starve_cnt <= '0;
                        end else if (req[1]) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end
                end
                ST_ACCESS: begin
                    err_q   <= align_err;
                    rdata_q <= (!we_q && !align_err) ? load_data : 32'h0;
                    merge_q <= mem_rd;
                end
                default: ;
            endcase
        end
    end

endmodule
